// File: rtl/alu_result_uart_tx.sv
// ALU result serializer: latches a result word and ships it as
// back-to-back 8N1 UART frames, least-significant byte first.
module alu_result_uart_tx #(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] i_result,
  input  logic                 i_send,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NBYTES = BUS_WIDTH / 8;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BW-1:0]  LAST_BAUD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] shreg;
  logic [2:0]           bit_idx;
  logic [BCW-1:0]       byte_cnt;
  logic [BW-1:0]        baud;

  logic       baud_end;
  logic [2:0] next_idx;

  assign baud_end = (baud == LAST_BAUD);
  assign next_idx = bit_idx + 3'd1;

  // o_tx is loaded with the level of the upcoming bit at each boundary,
  // so the line is a pure register output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      baud     <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
          if (i_send) begin
            shreg    <= i_result;
            byte_cnt <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            o_tx    <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_idx;
              o_tx    <= shreg[next_idx];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (byte_cnt < LAST_BYTE) begin
              shreg    <= shreg >> 8;
              byte_cnt <= byte_cnt + 1'b1;
              o_tx     <= 1'b0;
              state    <= START;
            end else begin
              o_tx   <= 1'b1;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx: decodes the TX line
// mid-bit from a per-cycle log and checks busy/done timing.
module tb_alu_result_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_result = '0;
  logic        i_send = 1'b0;
  logic        o_tx;
  logic        o_busy;
  logic        o_done;

  int n_cmp = 0;
  int n_err = 0;

  logic txq[$];
  logic busyq[$];
  logic doneq[$];
  int   busy_cnt;
  int   done_cnt;

  alu_result_uart_tx #(
    .BUS_WIDTH(16),
    .CLKS_PER_BIT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_result(i_result),
    .i_send(i_send),
    .o_tx(o_tx),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    txq.delete();
    busyq.delete();
    doneq.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      txq.push_back(o_tx);
      busyq.push_back(o_busy);
      doneq.push_back(o_done);
      if (o_busy === 1'b1) busy_cnt++;
      if (o_done === 1'b1) done_cnt++;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after accept.
  task automatic accept(input logic [15:0] val);
    i_result = val;
    i_send   = 1'b1;
    clear_log();
    step(1);
    i_send = 1'b0;
  endtask

  // base: log index of the first start-bit cycle; frame = {stop,data,start}
  task automatic chk_frame(input int base, input logic [7:0] exp,
                           input string tag);
    logic [9:0] f;
    f = '0;
    if (base + 160 > txq.size()) begin
      chk({tag, "_len"}, 32'(txq.size()), 32'(base + 160));
    end else begin
      for (int j = 0; j < 10; j++) f[j] = txq[base + 16 * j + 7];
      chk(tag, {22'd0, f}, {22'd0, 1'b1, exp, 1'b0});
    end
  endtask

  initial begin
    // 1: reset held with i_send high
    i_send = 1'b1;
    i_result = 16'h5555;
    clear_log();
    for (int c = 0; c < 2; c++) begin
      step(1);
      chk("rst_tx", o_tx, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
    end
    reset = 1'b0;
    step(1);
    chk("post_rst_busy", o_busy, 1);
    chk("post_rst_tx", o_tx, 0);
    i_send = 1'b0;
    step(20);
    reset = 1'b1;
    step(1);
    chk("abort0_tx", o_tx, 1);
    chk("abort0_busy", o_busy, 0);
    reset = 1'b0;
    step(3);

    // 2: basic send, latency and busy width
    accept(16'h0004);
    chk("lat_busy", o_busy, 1);
    chk("lat_tx", o_tx, 0);
    step(320);
    chk("b2_done", o_done, 1);
    chk("b2_busy_low", o_busy, 0);
    chk("b2_tx_idle", o_tx, 1);
    chk("b2_busy_cnt", busy_cnt, 320);
    chk("b2_done_cnt", done_cnt, 1);
    chk_frame(0, 8'h04, "b2_frame0");
    chk_frame(160, 8'h00, "b2_frame1");
    step(1);
    chk("b2_done_clr", o_done, 0);
    step(3);

    // 3: pattern and byte order
    accept(16'hA55A);
    step(325);
    chk_frame(0, 8'h5A, "b3_frame0");
    chk_frame(160, 8'hA5, "b3_frame1");
    chk("b3_busy_cnt", busy_cnt, 320);

    // 4: request while busy is ignored
    accept(16'h000F);
    step(48);
    i_result = 16'h0020;
    i_send = 1'b1;
    step(1);
    i_send = 1'b0;
    step(290);
    chk_frame(0, 8'h0F, "b4_frame0");
    chk_frame(160, 8'h00, "b4_frame1");
    chk("b4_busy_cnt", busy_cnt, 320);
    chk("b4_done_cnt", done_cnt, 1);
    chk("b4_idle_tx", o_tx, 1);

    // 5: continuous i_send
    i_result = 16'h1234;
    i_send = 1'b1;
    clear_log();
    step(641);
    i_send = 1'b0;
    step(5);
    chk_frame(0, 8'h34, "b5_t0_frame0");
    chk_frame(160, 8'h12, "b5_t0_frame1");
    chk_frame(321, 8'h34, "b5_t1_frame0");
    chk_frame(481, 8'h12, "b5_t1_frame1");
    chk("b5_gap_tx", txq[320], 1);
    chk("b5_gap_done", doneq[320], 1);
    chk("b5_gap_busy", busyq[320], 0);
    chk("b5_pre_gap_busy", busyq[319], 1);
    chk("b5_post_gap_busy", busyq[321], 1);
    chk("b5_busy_cnt", busy_cnt, 640);
    chk("b5_done_cnt", done_cnt, 2);

    // 6: reset during DATA of byte 0, then a clean transfer
    accept(16'h00FF);
    step(39);
    chk("b6_in_data_busy", o_busy, 1);
    reset = 1'b1;
    step(1);
    chk("b6_abort_tx", o_tx, 1);
    chk("b6_abort_busy", o_busy, 0);
    chk("b6_abort_done", o_done, 0);
    reset = 1'b0;
    step(2);
    accept(16'h00FF);
    step(330);
    chk_frame(0, 8'hFF, "b6_frame0");
    chk_frame(160, 8'h00, "b6_frame1");
    chk("b6_busy_cnt", busy_cnt, 320);
    chk("b6_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
